// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction-fetch slice: default word/address
// widths, the reset vector and the fetch FSM state encoding.
// No ports (package only).
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

   localparam int FETCH_WORD_WIDTH = 16;
   localparam int FETCH_ADDR_WIDTH = 16;
   localparam logic [FETCH_ADDR_WIDTH-1:0] FETCH_RESET_VECTOR = 16'h0000;

   // IDLE : no request outstanding
   // REQ  : request outstanding, its data will be kept
   // DROP : request outstanding, its data will be discarded (redirected)
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Two-entry FIFO holding fetched {instr, pc} pairs for the decoder.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          remove the head entry (ignored when empty)
//   flush        empty the FIFO; wins over pop and push
//   count        number of valid entries (0..2)
//   head_data    head entry, driven straight from the storage registers
// -----------------------------------------------------------------------------
module fetch_buffer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] entry_reg [2];
   logic             rd_ptr_reg;
   logic             wr_ptr_reg;
   logic [1:0]       count_reg;
   logic [1:0]       count_next;
   logic             push_eff;
   logic             pop_eff;

   assign push_eff = push && !flush;
   assign pop_eff  = pop && !flush && (count_reg != 2'd0);

   always_comb begin
      count_next = count_reg;
      if (flush) begin
         count_next = 2'd0;
      end else begin
         case ({push_eff, pop_eff})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            entry_reg[i] <= '0;
         end
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         count_reg <= count_next;
         if (flush) begin
            // Contents are left in place; only the pointers restart.
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
         end else begin
            if (push_eff) begin
               entry_reg[wr_ptr_reg] <= push_data;
               wr_ptr_reg            <= ~wr_ptr_reg;
            end
            if (pop_eff) begin
               rd_ptr_reg <= ~rd_ptr_reg;
            end
         end
      end
   end

   assign count     = count_reg;
   assign head_data = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetches instruction words from memory with at most one request outstanding
// and buffers up to two of them for the decoder. Handles branch redirects
// (including redirects that race an outstanding request) and a halt level.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_req/mem_addr  fetch request, held stable until mem_ack
//   mem_ack/mem_data  one-cycle completion pulse with the fetched word
//   branch_valid      one-cycle redirect strobe, branch_target = new pc
//   halt              level, blocks issue of new requests
//   instr/instr_pc    head instruction and its address
//   instr_valid       head valid; instr_ready from decoder completes transfer
// -----------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int                    WORD_WIDTH   = FETCH_WORD_WIDTH,
   parameter int                    ADDR_WIDTH   = FETCH_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = FETCH_RESET_VECTOR
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [WORD_WIDTH-1:0] mem_data,
   input  logic                  branch_valid,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic                  halt,
   output logic [WORD_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready
);

   fetch_state_t          state_reg, state_next;
   logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
   logic                  mem_req_reg, mem_req_next;
   logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [1:0]            fifo_count;
   logic [1:0]            count_after_pop;

   assign instr_valid = (fifo_count != 2'd0);
   assign fifo_pop    = instr_valid && instr_ready;
   // Counter wraps naturally at the top of the address space.
   assign pc_inc      = mem_addr_reg + ADDR_WIDTH'(1);
   assign count_after_pop = fifo_pop ? (fifo_count - 2'd1) : fifo_count;

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      mem_req_next  = mem_req_reg;
      mem_addr_next = mem_addr_reg;
      fifo_push     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (branch_valid) begin
               pc_next = branch_target;
            end else if (!halt && (fifo_count <= 2'd1)) begin
               state_next    = ST_REQ;
               mem_req_next  = 1'b1;
               mem_addr_next = pc_reg;
            end
         end
         ST_REQ: begin
            if (mem_ack && branch_valid) begin
               state_next   = ST_IDLE;
               mem_req_next = 1'b0;
               pc_next      = branch_target;
            end else if (mem_ack) begin
               fifo_push = 1'b1;
               pc_next   = pc_inc;
               // Keep streaming only if the slot freed by this push leaves
               // room for the next word (post-push count <= 1).
               if (!halt && (count_after_pop == 2'd0)) begin
                  mem_addr_next = pc_inc;
               end else begin
                  state_next   = ST_IDLE;
                  mem_req_next = 1'b0;
               end
            end else if (branch_valid) begin
               // Request cannot be withdrawn; wait it out and discard it.
               state_next = ST_DROP;
               pc_next    = branch_target;
            end
         end
         ST_DROP: begin
            if (branch_valid) begin
               pc_next = branch_target;
            end
            if (mem_ack) begin
               state_next   = ST_IDLE;
               mem_req_next = 1'b0;
            end
         end
         default: begin
            state_next   = ST_IDLE;
            mem_req_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         pc_reg       <= RESET_VECTOR;
         mem_req_reg  <= 1'b0;
         mem_addr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         mem_req_reg  <= mem_req_next;
         mem_addr_reg <= mem_addr_next;
      end
   end

   assign mem_req  = mem_req_reg;
   assign mem_addr = mem_addr_reg;

   fetch_buffer #(
      .WIDTH(WORD_WIDTH + ADDR_WIDTH)
   ) u_fetch_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({mem_data, mem_addr_reg}),
      .pop       (fifo_pop),
      .flush     (branch_valid),
      .count     (fifo_count),
      .head_data ({instr, instr_pc})
   );

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. Memory returns addr ^ 16'hA5A5, acking one
// cycle after it sees a request (auto mode) or when the bench pulses mem_ack.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic        branch_valid;
   logic [15:0] branch_target;
   logic        halt;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        mem_auto;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_data      (mem_data),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .halt          (halt),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; inputs are updated 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (mem_auto) mem_ack = mem_req && !mem_ack;
      else          mem_ack = 1'b0;
      mem_data     = mem_addr ^ 16'hA5A5;
      branch_valid = 1'b0;
   endtask

   // Wait (bounded) for the head, check it, then let the decoder take it.
   task automatic expect_instr(input logic [15:0] pc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (instr_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      checks++;
      assert (seen) else begin
         failures++;
         $error("FAIL instr_valid_timeout observed=0 expected=1 pc=%h", pc);
      end
      if (seen) begin
         check("instr_pc", {16'h0, instr_pc}, {16'h0, pc});
         check("instr", {16'h0, instr}, {16'h0, pc ^ 16'hA5A5});
         $display("transfer instr_pc=%h instr=%h", instr_pc, instr);
      end
      step();
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      halt         = 1'b0;
      branch_valid = 1'b0;
      mem_ack      = 1'b0;
      instr_ready  = 1'b1;
      mem_auto     = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      mem_ack       = 1'b0;
      mem_data      = 16'h0;
      branch_valid  = 1'b0;
      branch_target = 16'h0;
      halt          = 1'b0;
      instr_ready   = 1'b1;
      mem_auto      = 1'b1;
      step();
      step();
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
      check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instr_pc", {16'h0, instr_pc}, 32'h0);

      // In-order streaming from reset
      do_reset();
      expect_instr(16'h0000);
      expect_instr(16'h0001);
      expect_instr(16'h0002);
      expect_instr(16'h0003);

      // Decoder stalled: exactly two entries, then resume at pc 2
      do_reset();
      instr_ready = 1'b0;
      repeat (10) step();
      check("stall_mem_req", {31'h0, mem_req}, 32'h0);
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
      instr_ready = 1'b1;
      expect_instr(16'h0000);
      expect_instr(16'h0001);
      check("resume_empty", {31'h0, instr_valid}, 32'h0);
      check("resume_mem_req", {31'h0, mem_req}, 32'h1);
      check("resume_mem_addr", {16'h0, mem_addr}, 32'h0002);
      expect_instr(16'h0002);

      // Redirect while request to 5 outstanding
      do_reset();
      expect_instr(16'h0000);
      expect_instr(16'h0001);
      expect_instr(16'h0002);
      expect_instr(16'h0003);
      mem_auto = 1'b0;
      expect_instr(16'h0004);
      check("pre_drop_req", {31'h0, mem_req}, 32'h1);
      check("pre_drop_addr", {16'h0, mem_addr}, 32'h0005);
      branch_target = 16'h0040;
      branch_valid  = 1'b1;
      step();
      step();
      step();
      check("drop_hold_req", {31'h0, mem_req}, 32'h1);
      check("drop_hold_addr", {16'h0, mem_addr}, 32'h0005);
      mem_ack = 1'b1;
      step();
      check("drop_done_req", {31'h0, mem_req}, 32'h0);
      check("drop_discard", {31'h0, instr_valid}, 32'h0);
      mem_auto = 1'b1;
      expect_instr(16'h0040);
      expect_instr(16'h0041);

      // Redirect coincident with ack and pop
      do_reset();
      instr_ready = 1'b0;
      step();
      step();
      step();
      check("race_pre_valid", {31'h0, instr_valid}, 32'h1);
      check("race_pre_ack", {31'h0, mem_ack}, 32'h1);
      branch_target = 16'h0100;
      branch_valid  = 1'b1;
      instr_ready   = 1'b1;
      step();
      check("race_flushed", {31'h0, instr_valid}, 32'h0);
      check("race_mem_req", {31'h0, mem_req}, 32'h0);
      step();
      check("race_refetch_req", {31'h0, mem_req}, 32'h1);
      check("race_refetch_addr", {16'h0, mem_addr}, 32'h0100);
      expect_instr(16'h0100);

      // Flush with a full FIFO and a simultaneous pop
      do_reset();
      instr_ready = 1'b0;
      repeat (8) step();
      branch_target = 16'h0200;
      branch_valid  = 1'b1;
      instr_ready   = 1'b1;
      step();
      check("full_flush", {31'h0, instr_valid}, 32'h0);
      expect_instr(16'h0200);

      // Address wrap
      do_reset();
      branch_target = 16'hFFFF;
      branch_valid  = 1'b1;
      expect_instr(16'hFFFF);
      expect_instr(16'h0000);

      // Halt during an outstanding request, then reset mid-request
      do_reset();
      mem_auto      = 1'b0;
      instr_ready   = 1'b0;
      branch_target = 16'h0020;
      branch_valid  = 1'b1;
      step();
      step();
      check("halt_issue_addr", {16'h0, mem_addr}, 32'h0020);
      halt = 1'b1;
      step();
      step();
      check("halt_keep_req", {31'h0, mem_req}, 32'h1);
      mem_ack = 1'b1;
      step();
      check("halt_delivered_valid", {31'h0, instr_valid}, 32'h1);
      check("halt_delivered_pc", {16'h0, instr_pc}, 32'h0020);
      check("halt_delivered_instr", {16'h0, instr}, 32'h0000A585);
      repeat (3) step();
      check("halt_no_issue", {31'h0, mem_req}, 32'h0);
      halt = 1'b0;
      step();
      check("unhalt_req", {31'h0, mem_req}, 32'h1);
      check("unhalt_addr", {16'h0, mem_addr}, 32'h0021);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_req", {31'h0, mem_req}, 32'h0);
      check("async_rst_addr", {16'h0, mem_addr}, 32'h0);
      check("async_rst_valid", {31'h0, instr_valid}, 32'h0);
      check("async_rst_pc", {16'h0, instr_pc}, 32'h0);
      check("async_rst_instr", {16'h0, instr}, 32'h0);
      halt = 1'b1;
      step();
      rst_n   = 1'b1;
      mem_ack = 1'b1;
      step();
      check("late_ack_ignored", {31'h0, instr_valid}, 32'h0);
      check("late_ack_no_req", {31'h0, mem_req}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
